// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SPI master serial-clock generator and transfer sequencer.
// Divides i_clk into SCLK. Drives chip-select and the per-byte load strobe.
// Emits leading/trailing edge pulses plus the bit and byte counters.
// Optional feature macro: SPI_CS_GUARD_EN adds CS setup/hold guard states.
`timescale 1ns/1ps

module spi_sclk_gen #(
    parameter int CLK_DIV  = 4,
    parameter int CS_GUARD = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [2:0] i_num_bytes,
    input  logic       i_cpol,
    output logic       o_spi_clk,
    output logic       o_cs_n,
    output logic       o_tx_vd,
    output logic       o_leading_edge,
    output logic       o_trailing_edge,
    output logic [2:0] o_bit_count,
    output logic [2:0] o_byte_count,
    output logic       o_busy,
    output logic       o_done
);

    localparam int DW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

`ifdef SPI_CS_GUARD_EN
    localparam int GUARD_MIN = 1;
    localparam int GW = (CS_GUARD < 2) ? 1 : $clog2(CS_GUARD);
    localparam logic [GW-1:0] GUARD_LAST = GW'(CS_GUARD - 1);
`else
    localparam int GUARD_MIN = 0;
`endif

    // Reject illegal divider / guard settings at elaboration.
    generate
        if (CLK_DIV < 2 || CS_GUARD < GUARD_MIN) begin : g_bad_param
            $error("spi_sclk_gen: illegal CLK_DIV or CS_GUARD");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [2:0]      num_q, num_d;
    logic            cpol_q, cpol_d;
    logic            byte_end_q, byte_end_d;
    logic            spi_clk_q, spi_clk_d;
    logic            cs_n_q, cs_n_d;
    logic            tx_vd_q, tx_vd_d;
    logic            lead_q, lead_d;
    logic            trail_q, trail_d;
    logic [2:0]      bit_q, bit_d;
    logic [2:0]      byte_q, byte_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef SPI_CS_GUARD_EN
    logic [GW-1:0]   guard_q, guard_d;
`endif

    // Next-state and next-output decode; every output is the registered
    // image of what the following cycle should show.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        num_d      = num_q;
        cpol_d     = cpol_q;
        byte_end_d = 1'b0;
        spi_clk_d  = spi_clk_q;
        cs_n_d     = cs_n_q;
        tx_vd_d    = 1'b0;
        lead_d     = 1'b0;
        trail_d    = 1'b0;
        bit_d      = bit_q;
        byte_d     = byte_q;
        done_d     = 1'b0;
`ifdef SPI_CS_GUARD_EN
        guard_d    = guard_q;
`endif
        case (state_q)
            IDLE: begin
                spi_clk_d = i_cpol;
                if (i_start && !i_abort) begin
                    num_d  = i_num_bytes;
                    cpol_d = i_cpol;
                    cs_n_d = 1'b0;
                    bit_d  = 3'd0;
                    byte_d = 3'd0;
`ifdef SPI_CS_GUARD_EN
                    state_d = SETUP;
                    guard_d = '0;
`else
                    state_d = LOAD;
                    tx_vd_d = 1'b1;
`endif
                end
            end
`ifdef SPI_CS_GUARD_EN
            SETUP: begin
                if (guard_q == GUARD_LAST) begin
                    state_d = LOAD;
                    tx_vd_d = 1'b1;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
            HOLD: begin
                if (guard_q == GUARD_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    cs_n_d  = 1'b1;
                    bit_d   = 3'd0;
                    byte_d  = 3'd0;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
`endif
            LOAD: begin
                state_d = SHIFT;
                div_d   = '0;
            end
            SHIFT: begin
                div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
                if (byte_end_q) begin
                    // Cycle showing the 8th trailing edge: next byte or finish.
                    if (byte_q == num_q) begin
`ifdef SPI_CS_GUARD_EN
                        state_d = HOLD;
                        guard_d = '0;
`else
                        state_d = DONE;
                        done_d  = 1'b1;
                        cs_n_d  = 1'b1;
                        bit_d   = 3'd0;
                        byte_d  = 3'd0;
`endif
                    end else begin
                        state_d = LOAD;
                        tx_vd_d = 1'b1;
                        bit_d   = 3'd0;
                        byte_d  = byte_q + 3'd1;
                    end
                end else if (div_d == DIV_LAST) begin
                    // Toggle lands in the cycle whose divider value is DIV_LAST.
                    spi_clk_d = ~spi_clk_q;
                    if (spi_clk_q == cpol_q) begin
                        lead_d = 1'b1;
                    end else begin
                        trail_d = 1'b1;
                        if (bit_q == 3'd7) byte_end_d = 1'b1;
                        else               bit_d      = bit_q + 3'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);

        // Abort outranks every transition; SCLK parks at the latched idle level.
        if (i_abort && state_q != IDLE) begin
            state_d    = IDLE;
            div_d      = '0;
            byte_end_d = 1'b0;
            spi_clk_d  = cpol_q;
            cs_n_d     = 1'b1;
            tx_vd_d    = 1'b0;
            lead_d     = 1'b0;
            trail_d    = 1'b0;
            bit_d      = 3'd0;
            byte_d     = 3'd0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            num_q      <= 3'd0;
            cpol_q     <= 1'b0;
            byte_end_q <= 1'b0;
            spi_clk_q  <= 1'b0;
            cs_n_q     <= 1'b1;
            tx_vd_q    <= 1'b0;
            lead_q     <= 1'b0;
            trail_q    <= 1'b0;
            bit_q      <= 3'd0;
            byte_q     <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SPI_CS_GUARD_EN
            guard_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            num_q      <= num_d;
            cpol_q     <= cpol_d;
            byte_end_q <= byte_end_d;
            spi_clk_q  <= spi_clk_d;
            cs_n_q     <= cs_n_d;
            tx_vd_q    <= tx_vd_d;
            lead_q     <= lead_d;
            trail_q    <= trail_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SPI_CS_GUARD_EN
            guard_q    <= guard_d;
`endif
        end
    end

    assign o_spi_clk       = spi_clk_q;
    assign o_cs_n          = cs_n_q;
    assign o_tx_vd         = tx_vd_q;
    assign o_leading_edge  = lead_q;
    assign o_trailing_edge = trail_q;
    assign o_bit_count     = bit_q;
    assign o_byte_count    = byte_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb_spi_sclk_gen: directed bench for spi_sclk_gen (CLK_DIV=4, CS_GUARD=2).
// Event times are logged relative to the cycle in which i_start is high.
`timescale 1ns/1ps

module tb_spi_sclk_gen;

`ifdef SPI_CS_GUARD_EN
    localparam int G = 2;
`else
    localparam int G = 0;
`endif
    localparam int BL = 65;   // 1 + 16*CLK_DIV cycles per byte

    logic       clk = 1'b0;
    logic       i_rst = 1'b1, i_start = 1'b0, i_abort = 1'b0, i_cpol = 1'b0;
    logic [2:0] i_num_bytes = 3'd0;
    logic       o_spi_clk, o_cs_n, o_tx_vd, o_leading_edge, o_trailing_edge;
    logic [2:0] o_bit_count, o_byte_count;
    logic       o_busy, o_done;

    int errors = 0, checks = 0, cyc = 0, t0 = 0;
    int   lead_q[$], trail_q[$], txvd_q[$], done_q[$], bytec_q[$];
    logic lead_lvl_q[$], done_cs_q[$];

    spi_sclk_gen #(.CLK_DIV(4), .CS_GUARD(2)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_num_bytes(i_num_bytes), .i_cpol(i_cpol),
        .o_spi_clk(o_spi_clk), .o_cs_n(o_cs_n), .o_tx_vd(o_tx_vd),
        .o_leading_edge(o_leading_edge), .o_trailing_edge(o_trailing_edge),
        .o_bit_count(o_bit_count), .o_byte_count(o_byte_count),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle and log the pulses visible in the new cycle.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (o_leading_edge) begin lead_q.push_back(cyc - t0); lead_lvl_q.push_back(o_spi_clk); end
        if (o_trailing_edge) trail_q.push_back(cyc - t0);
        if (o_tx_vd) begin txvd_q.push_back(cyc - t0); bytec_q.push_back(int'(o_byte_count)); end
        if (o_done) begin done_q.push_back(cyc - t0); done_cs_q.push_back(o_cs_n); end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr();
        lead_q.delete(); trail_q.delete(); txvd_q.delete(); done_q.delete();
        bytec_q.delete(); lead_lvl_q.delete(); done_cs_q.delete();
        t0 = cyc;
    endtask

    // i_start high for exactly one cycle (relative cycle 0); returns at rel 1.
    task automatic start_xfer(input logic [2:0] nb, input logic cp);
        i_num_bytes = nb;
        i_cpol      = cp;
        clr();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    // Expected event schedule of a single-byte transfer, checked at rel 71.
    task automatic check_1b(input string tag);
        chk({tag, "_lead_n"}, lead_q.size(), 8);
        chk({tag, "_trail_n"}, trail_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_lead_t"}, lead_q[i], 5 + G + 8 * i);
            chk({tag, "_trail_t"}, trail_q[i], 9 + G + 8 * i);
        end
        chk({tag, "_txvd_n"}, txvd_q.size(), 1);
        chk({tag, "_txvd_t"}, txvd_q[0], 1 + G);
        chk({tag, "_done_n"}, done_q.size(), 1);
        chk({tag, "_done_t"}, done_q[0], 66 + 2 * G);
        chk({tag, "_done_cs"}, done_cs_q[0], 1);
        chk({tag, "_busy_end"}, o_busy, 0);
        chk({tag, "_cs_end"}, o_cs_n, 1);
    endtask

    initial begin
        // Reset state
        steps(3);
        chk("rst_cs_n", o_cs_n, 1);
        chk("rst_sclk", o_spi_clk, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_txvd", o_tx_vd, 0);
        chk("rst_done", o_done, 0);
        chk("rst_cnt", {o_bit_count, o_byte_count}, 0);
        i_rst = 1'b0;
        steps(6);

        // Single byte, cpol=0
        start_xfer(3'd0, 1'b0);
        chk("s1_cs_low", o_cs_n, 0);
        chk("s1_busy", o_busy, 1);
        chk("s1_bitcnt", o_bit_count, 0);
        steps(70);
        check_1b("s1");

        // Three bytes, cpol=1; input changes mid-transfer are ignored
        i_cpol = 1'b1;
        steps(2);
        chk("s2_idle_lvl", o_spi_clk, 1);
        start_xfer(3'd2, 1'b1);
        i_cpol = 1'b0;
        i_num_bytes = 3'd0;
        steps(200);
        chk("s2_txvd_n", txvd_q.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk("s2_txvd_t", txvd_q[k], 1 + G + BL * k);
            chk("s2_bytecnt", bytec_q[k], k);
        end
        chk("s2_lead_n", lead_q.size(), 24);
        chk("s2_trail_n", trail_q.size(), 24);
        chk("s2_first_lvl", lead_lvl_q[0], 0);
        chk("s2_done_n", done_q.size(), 1);
        chk("s2_done_t", done_q[0], 196 + 2 * G);

        // Restart while busy is ignored
        steps(2);
        start_xfer(3'd0, 1'b0);
        steps(19);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        steps(50);
        check_1b("s3");

        // Abort and start together in idle: abort wins
        steps(2);
        clr();
        i_start = 1'b1;
        i_abort = 1'b1;
        step();
        i_start = 1'b0;
        i_abort = 1'b0;
        chk("sa_busy", o_busy, 0);
        chk("sa_cs_n", o_cs_n, 1);
        steps(10);
        chk("sa_txvd_n", txvd_q.size(), 0);

        // Abort at the 3rd leading edge (cpol=1)
        i_cpol = 1'b1;
        steps(2);
        start_xfer(3'd0, 1'b1);
        for (int i = 0; i < 100 && lead_q.size() < 3; i++) step();
        chk("s4_reach_lead3", lead_q.size(), 3);
        chk("s4_sclk_active", o_spi_clk, 0);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("s4_cs_n", o_cs_n, 1);
        chk("s4_busy", o_busy, 0);
        chk("s4_cnt", {o_bit_count, o_byte_count}, 0);
        chk("s4_sclk_idle", o_spi_clk, 1);
        chk("s4_txvd", o_tx_vd, 0);
        clr();
        steps(80);
        chk("s4_no_done", done_q.size(), 0);
        chk("s4_no_edges", lead_q.size() + trail_q.size(), 0);
        i_cpol = 1'b0;
        step();
        start_xfer(3'd0, 1'b0);
        chk("s4b_cs_low", o_cs_n, 0);
        steps(70);
        check_1b("s4b");

        // Reset in the middle of byte 1 of a 2-byte transfer (cpol=1)
        i_cpol = 1'b1;
        steps(2);
        start_xfer(3'd1, 1'b1);
        steps(99);
        chk("s5_bytecnt", o_byte_count, 1);
        chk("s5_busy", o_busy, 1);
        i_rst = 1'b1;
        step();
        chk("s5_sclk", o_spi_clk, 0);
        chk("s5_cs_n", o_cs_n, 1);
        chk("s5_busy0", o_busy, 0);
        chk("s5_pulses", {o_tx_vd, o_leading_edge, o_trailing_edge, o_done}, 0);
        chk("s5_cnt", {o_bit_count, o_byte_count}, 0);
        i_rst = 1'b0;
        clr();
        steps(100);
        chk("s5_no_edges", lead_q.size() + trail_q.size(), 0);
        chk("s5_no_txvd", txvd_q.size(), 0);
        chk("s5_no_done", done_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
